// File: rtl/sd_fifo_tx_filler.sv
// sd_fifo_tx_filler: Wishbone read master that fetches xfer_words 32-bit words
// from dma_adr upward and pushes them one at a time into the TX FIFO.
module sd_fifo_tx_filler (
   input  logic        wclk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] dma_adr,
   input  logic [15:0] xfer_words,
   output logic [31:0] m_wb_adr_o,
   output logic        m_wb_cyc_o,
   output logic        m_wb_stb_o,
   output logic        m_wb_we_o,
   output logic [3:0]  m_wb_sel_o,
   input  logic [31:0] m_wb_dat_i,
   input  logic        m_wb_ack_i,
   input  logic        m_wb_err_i,
   output logic [31:0] fifo_dat_o,
   output logic        fifo_wr_o,
   input  logic        fifo_full_i,
   output logic        done_o,
   output logic        err_o
);
   typedef enum logic [2:0] {IDLE, WAIT, REQ, WRITE, DONE, ERR} state_t;
   state_t      state;
   logic        en_q;
   logic [31:0] addr;
   logic [15:0] cnt;
   assign m_wb_we_o  = 1'b0;
   assign m_wb_sel_o = 4'hF;
   assign m_wb_adr_o = addr;
   always_ff @(posedge wclk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         en_q       <= 1'b0;
         addr       <= '0;
         cnt        <= '0;
         m_wb_cyc_o <= 1'b0;
         m_wb_stb_o <= 1'b0;
         fifo_dat_o <= '0;
         fifo_wr_o  <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         en_q      <= en;
         fifo_wr_o <= 1'b0;
         case (state)
            IDLE:
               if (en && !en_q) begin
                  addr <= dma_adr;
                  cnt  <= xfer_words;
                  if (xfer_words == 16'd0) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else
                     state <= WAIT;
               end
            WAIT:
               if (!en)
                  state <= IDLE;
               else if (!fifo_full_i) begin
                  state      <= REQ;
                  m_wb_cyc_o <= 1'b1;
                  m_wb_stb_o <= 1'b1;
               end
            // Slave error wins over a simultaneous ack; an ack still beats an abort.
            REQ:
               if (m_wb_err_i) begin
                  state      <= ERR;
                  err_o      <= 1'b1;
                  m_wb_cyc_o <= 1'b0;
                  m_wb_stb_o <= 1'b0;
               end else if (m_wb_ack_i) begin
                  state      <= WRITE;
                  fifo_dat_o <= m_wb_dat_i;
                  fifo_wr_o  <= 1'b1;
                  addr       <= addr + 32'd4;
                  cnt        <= cnt - 16'd1;
                  m_wb_cyc_o <= 1'b0;
                  m_wb_stb_o <= 1'b0;
               end else if (!en) begin
                  state      <= IDLE;
                  m_wb_cyc_o <= 1'b0;
                  m_wb_stb_o <= 1'b0;
               end
            WRITE:
               if (cnt == 16'd0) begin
                  state  <= DONE;
                  done_o <= 1'b1;
               end else
                  state <= WAIT;
            DONE:
               if (!en) begin
                  state  <= IDLE;
                  done_o <= 1'b0;
               end
            ERR:
               if (!en) begin
                  state <= IDLE;
                  err_o <= 1'b0;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_sd_fifo_tx_filler.sv
// tb_sd_fifo_tx_filler: scoreboard bench; expected addresses and FIFO data are
// queued when a transfer is launched and popped as the DUT issues them.
module tb_sd_fifo_tx_filler;
   logic        wclk = 1'b0, rst = 1'b1, en = 1'b0;
   logic [31:0] dma_adr = '0, m_wb_dat_i = '0;
   logic [15:0] xfer_words = '0;
   logic        m_wb_ack_i = 1'b0, m_wb_err_i = 1'b0, fifo_full_i = 1'b0;
   logic [31:0] m_wb_adr_o, fifo_dat_o;
   logic [3:0]  m_wb_sel_o;
   logic        m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, fifo_wr_o, done_o, err_o;
   int          vectors = 0, miscompares = 0;
   int          acc, writes, err_at = 0, lat;
   logic        prev_cyc = 1'b0, stall = 1'b0;
   logic [31:0] exp_adr[$], exp_dat[$];
   sd_fifo_tx_filler dut (
      .wclk(wclk), .rst(rst), .en(en), .dma_adr(dma_adr), .xfer_words(xfer_words),
      .m_wb_adr_o(m_wb_adr_o), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
      .m_wb_we_o(m_wb_we_o), .m_wb_sel_o(m_wb_sel_o), .m_wb_dat_i(m_wb_dat_i),
      .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i), .fifo_dat_o(fifo_dat_o),
      .fifo_wr_o(fifo_wr_o), .fifo_full_i(fifo_full_i), .done_o(done_o), .err_o(err_o)
   );
   always #5 wclk = ~wclk;
   function automatic logic [31:0] rdata(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic load(input logic [31:0] adr, input int nadr, input int ndat);
      exp_adr.delete();
      exp_dat.delete();
      for (int i = 0; i < nadr; i++) exp_adr.push_back(adr + 32'(4 * i));
      for (int i = 0; i < ndat; i++) exp_dat.push_back(rdata(adr + 32'(4 * i)));
      acc = 0;
      writes = 0;
      dma_adr = adr;
   endtask
   // One clock: sample DUT outputs just after the edge, then drive the slave reply.
   task automatic tick();
      @(posedge wclk);
      #1;
      if (m_wb_cyc_o && !prev_cyc) begin
         acc++;
         if (exp_adr.size() == 0) check("adr_unexpected", m_wb_adr_o, 32'hxxxx_xxxx);
         else check("adr", m_wb_adr_o, exp_adr.pop_front());
      end
      if (fifo_wr_o) begin
         writes++;
         if (exp_dat.size() == 0) check("dat_unexpected", fifo_dat_o, 32'hxxxx_xxxx);
         else check("dat", fifo_dat_o, exp_dat.pop_front());
      end
      prev_cyc   = m_wb_cyc_o;
      m_wb_ack_i = m_wb_cyc_o && m_wb_stb_o && !stall;
      m_wb_err_i = m_wb_cyc_o && m_wb_stb_o && (acc == err_at);
      m_wb_dat_i = rdata(m_wb_adr_o);
   endtask
   task automatic run_done(output int n);
      n = 0;
      while (!done_o && n < 60) begin
         tick();
         n++;
      end
      check("done_reached", {31'd0, done_o}, 32'd1);
   endtask
   task automatic finish_xfer(input string tag);
      check({tag, "_left"}, 32'(exp_adr.size() + exp_dat.size()), 32'd0);
      en = 1'b0;
      tick();
      check({tag, "_idle"}, {30'd0, done_o, err_o}, 32'd0);
   endtask
   initial begin
      #2;
      check("rst_adr", m_wb_adr_o, 32'd0);
      check("rst_dat", fifo_dat_o, 32'd0);
      check("rst_ctl", {27'd0, m_wb_cyc_o, m_wb_stb_o, fifo_wr_o, done_o, err_o}, 32'd0);
      check("rst_we_sel", {27'd0, m_wb_we_o, m_wb_sel_o}, 32'h0000_000F);
      @(negedge wclk);
      rst = 1'b0;
      tick();
      load(32'h0000_1000, 3, 3);
      xfer_words = 16'd3;
      en = 1'b1;
      tick();
      run_done(lat);
      check("s1_latency", 32'(lat), 32'd9);
      check("s1_writes", 32'(writes), 32'd3);
      tick();
      check("s1_done_held", {31'd0, done_o}, 32'd1);
      finish_xfer("s1");
      load(32'h0000_2000, 3, 3);
      en = 1'b1;
      for (int i = 0; i < 20 && writes == 0; i++) tick();
      fifo_full_i = 1'b1;
      begin
         logic cyc_seen = 1'b0;
         for (int i = 0; i < 5; i++) begin
            tick();
            cyc_seen |= m_wb_cyc_o;
         end
         check("s2_cyc_while_full", {31'd0, cyc_seen}, 32'd0);
      end
      check("s2_writes_while_full", 32'(writes), 32'd1);
      fifo_full_i = 1'b0;
      tick();
      check("s2_req_after_full", {30'd0, m_wb_cyc_o, m_wb_stb_o}, 32'd3);
      run_done(lat);
      check("s2_writes", 32'(writes), 32'd3);
      finish_xfer("s2");
      load(32'h0000_3000, 2, 1);
      err_at = 2;
      en = 1'b1;
      for (int i = 0; i < 30 && !err_o; i++) tick();
      check("s3_err", {31'd0, err_o}, 32'd1);
      check("s3_cyc", {31'd0, m_wb_cyc_o}, 32'd0);
      tick();
      check("s3_writes", 32'(writes), 32'd1);
      err_at = 0;
      finish_xfer("s3");
      load(32'hFFFF_FFFC, 2, 2);
      xfer_words = 16'd2;
      en = 1'b1;
      tick();
      run_done(lat);
      check("s4_writes", 32'(writes), 32'd2);
      finish_xfer("s4");
      load(32'h0000_4000, 0, 0);
      xfer_words = 16'd0;
      en = 1'b1;
      tick();
      check("s5_done", {31'd0, done_o}, 32'd1);
      tick();
      check("s5_no_bus", 32'(acc), 32'd0);
      finish_xfer("s5");
      load(32'h0000_5000, 1, 0);
      xfer_words = 16'd4;
      stall = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 10 && !m_wb_cyc_o; i++) tick();
      tick();
      check("s6_stalled_cyc", {31'd0, m_wb_cyc_o}, 32'd1);
      en = 1'b0;
      tick();
      check("s6_abort_cyc", {30'd0, m_wb_cyc_o, m_wb_stb_o}, 32'd0);
      tick();
      check("s6_writes", 32'(writes), 32'd0);
      check("s6_flags", {30'd0, done_o, err_o}, 32'd0);
      stall = 1'b0;
      load(32'h0000_6000, 1, 0);
      stall = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 10 && !m_wb_cyc_o; i++) tick();
      tick();
      rst = 1'b1;
      #1;
      check("s7_rst_ctl", {27'd0, m_wb_cyc_o, m_wb_stb_o, fifo_wr_o, done_o, err_o}, 32'd0);
      check("s7_rst_adr", m_wb_adr_o, 32'd0);
      check("s7_rst_dat", fifo_dat_o, 32'd0);
      @(negedge wclk);
      rst = 1'b0;
      en = 1'b0;
      stall = 1'b0;
      tick();
      load(32'h0000_7000, 1, 1);
      xfer_words = 16'd1;
      en = 1'b1;
      tick();
      run_done(lat);
      check("s7_writes", 32'(writes), 32'd1);
      finish_xfer("s7");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sd_fifo_tx_filler.md
SD_FIFO_TX_FILLER -- requirements
Module: sd_fifo_tx_filler

Interface
REQ-001 SHALL use reset rst (asynchronous, active-high) and clock wclk; all logic SHALL be clocked on posedge wclk.
REQ-002 Port wclk  in  1  system/write clock, shared with the TX FIFO write side.
REQ-003 Port rst  in  1  asynchronous active-high reset.
REQ-004 Port en  in  1  transfer enable; a rising edge starts a transfer, and low aborts the transfer and returns to idle.
REQ-005 Port dma_adr  in  32  start byte address, sampled on the en rising edge.
REQ-006 Port xfer_words  in  16  number of 32-bit words to move, sampled on the en rising edge.
REQ-007 Port m_wb_adr_o  out  32  Wishbone master address.
REQ-008 Port m_wb_cyc_o, m_wb_stb_o  out  1 each  Wishbone cycle and strobe.
REQ-009 Port m_wb_we_o  out  1  constant 0 (read only).
REQ-010 Port m_wb_sel_o  out  4  constant 4'hF.
REQ-011 Port m_wb_dat_i  in  32  read data.
REQ-012 Port m_wb_ack_i, m_wb_err_i  in  1 each  slave acknowledge and slave error.
REQ-013 Port fifo_dat_o  out  32  data to the TX FIFO d input.
REQ-014 Port fifo_wr_o  out  1  TX FIFO write strobe.
REQ-015 Port fifo_full_i  in  1  TX FIFO full flag.
REQ-016 Port done_o, err_o  out  1 each  transfer complete; bus error.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT, REQ, WRITE, DONE and ERR, with exactly one state active at a time.
REQ-018 IDLE: on en=1 with en_q=0 (en registered one cycle), the block SHALL load addr<=dma_adr and cnt<=xfer_words; it SHALL then go to DONE if xfer_words==0, otherwise to WAIT.
REQ-019 WAIT: if en=0 the block SHALL go to IDLE; otherwise, if fifo_full_i=0 it SHALL go to REQ; otherwise it SHALL stay in WAIT.
REQ-020 REQ: m_wb_cyc_o=m_wb_stb_o=1 and m_wb_adr_o=addr, held stable until ack, err or abort; a slave ack in the first REQ cycle SHALL be accepted.
REQ-021 REQ, ack=1 and err=0: the block SHALL latch fifo_dat_o<=m_wb_dat_i, set addr<=addr+4 (wraps modulo 2^32), set cnt<=cnt-1, deassert cyc/stb on the next cycle, and go to WRITE.
REQ-022 REQ, err=1: the error SHALL take priority over a simultaneous ack; the block SHALL go to ERR, deassert cyc/stb, and perform no FIFO write.
REQ-023 REQ, en=0 (without ack or err): the block SHALL abort by deasserting cyc/stb on the next cycle and going to IDLE; no FIFO write SHALL occur.
REQ-024 WRITE: fifo_wr_o=1 for exactly this one cycle; the block SHALL then go to DONE if cnt==0, otherwise to WAIT, even if en=0 (an already-fetched word is always written).
REQ-025 fifo_wr_o SHALL never be high in any state other than WRITE; there SHALL be at most one outstanding word, so the full check in WAIT guarantees no overflow.
REQ-026 Minimum throughput SHALL be 3 cycles per word (WAIT, REQ with immediate ack, WRITE).
REQ-027 DONE: done_o=1, held until en=0, then the block SHALL go to IDLE.
REQ-028 ERR: err_o=1, held until en=0, then the block SHALL go to IDLE; addr and cnt SHALL freeze.
REQ-029 m_wb_ack_i and m_wb_err_i SHALL be ignored outside REQ.
REQ-030 A new en rising edge SHALL only be recognised in IDLE.

Reset
REQ-031 On rst=1 the block SHALL immediately (asynchronously) enter IDLE.
REQ-032 On rst=1 the following outputs SHALL reset to 0: m_wb_adr_o, m_wb_cyc_o, m_wb_stb_o, fifo_dat_o, fifo_wr_o, done_o and err_o; en_q, addr and cnt SHALL also reset to 0.
REQ-033 m_wb_we_o SHALL remain 0 and m_wb_sel_o SHALL remain 4'hF at all times, including during reset.
REQ-034 Reset asserted during REQ SHALL drop cyc/stb in the same cycle, with no FIFO write.

Verification
REQ-035 Scenario: dma_adr=0x1000, xfer_words=3, slave acks immediately, FIFO never full -> adr sequence 0x1000, 0x1004, 0x1008; three fifo_wr_o pulses with the returned data; done_o=1 at cycle 9 after the en edge.
REQ-036 Scenario: fifo_full_i=1 asserted before the 2nd word -> the block stays in WAIT with cyc=0; after full deasserts, REQ follows 1 cycle later; 3 words total; no write while full.
REQ-037 Scenario: m_wb_err_i on the 2nd access -> exactly 1 FIFO write, err_o=1, cyc=0; err_o clears and the block returns to IDLE after en=0.
REQ-038 Scenario: dma_adr=0xFFFFFFFC, xfer_words=2 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-039 Scenario: xfer_words=0 -> done_o=1 with no bus cycle; en dropped in REQ with a stalled slave -> cyc drops the next cycle, the block goes to IDLE, and no write occurs.
REQ-040 Scenario: rst pulsed mid-REQ -> all outputs 0 immediately; a fresh en edge restarts from the new dma_adr.
